// File: rtl/spi_controller.sv
// rtl/spi_controller.sv - SPI mode-0 initiator turning one {rw, addr, data} request into one 16-bit frame
module spi_controller #(
  parameter int CLK_DIV  = 4,
  parameter int CS_LEAD  = 4,
  parameter int CS_LAG   = 4,
  parameter int IDLE_GAP = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rw,
  input  logic [6:0] req_addr,
  input  logic [7:0] req_data,
  output logic       nCS,
  output logic       SCLK,
  output logic       COPI,
  output logic       busy,
  output logic       done
);

  localparam int DW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int TMAX0 = (CS_LEAD > CS_LAG) ? CS_LEAD : CS_LAG;
  localparam int TMAX  = (TMAX0 > IDLE_GAP) ? TMAX0 : IDLE_GAP;
  localparam int TW    = $clog2(TMAX + 1);

  typedef enum logic [2:0] {IDLE, LEAD, SHIFT, LAG, GAP} state_t;

  state_t          state, state_n;
  logic [TW-1:0]   tmr, tmr_n;
  logic [DW-1:0]   div_cnt, div_n;
  logic [3:0]      bit_cnt, bit_n;
  logic [15:0]     shift_reg, shift_n;
  logic            ncs_q, ncs_n;
  logic            sclk_q, sclk_n;
  logic            copi_q, copi_n;
  logic            done_q, done_n;

  assign req_ready = (state == IDLE) && rst_n;
  assign busy      = (state != IDLE);
  assign nCS       = ncs_q;
  assign SCLK      = sclk_q;
  assign COPI      = copi_q;
  assign done      = done_q;

  always_comb begin
    state_n = state;
    tmr_n   = tmr;
    div_n   = div_cnt;
    bit_n   = bit_cnt;
    shift_n = shift_reg;
    ncs_n   = ncs_q;
    sclk_n  = sclk_q;
    copi_n  = copi_q;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          shift_n = {req_rw, req_addr, req_data};
          ncs_n   = 1'b0;
          copi_n  = req_rw;
          tmr_n   = '0;
          state_n = LEAD;
        end
      end
      LEAD: begin
        if (tmr == TW'(CS_LEAD - 1)) begin
          tmr_n   = '0;
          div_n   = '0;
          bit_n   = 4'd0;
          state_n = SHIFT;
        end else begin
          tmr_n = tmr + 1'b1;
        end
      end
      SHIFT: begin
        if (div_cnt == DW'(CLK_DIV - 1)) begin
          div_n  = '0;
          sclk_n = !sclk_q;
          // Falling SCLK: present the next bit in the same cycle so it is stable for a full low half
          if (sclk_q) begin
            if (bit_cnt == 4'd15) begin
              copi_n  = 1'b0;
              tmr_n   = '0;
              state_n = LAG;
            end else begin
              bit_n   = bit_cnt + 4'd1;
              shift_n = {shift_reg[14:0], 1'b0};
              copi_n  = shift_reg[14];
            end
          end
        end else begin
          div_n = div_cnt + 1'b1;
        end
      end
      LAG: begin
        if (tmr == TW'(CS_LAG - 1)) begin
          ncs_n   = 1'b1;
          done_n  = 1'b1;
          tmr_n   = '0;
          state_n = GAP;
        end else begin
          tmr_n = tmr + 1'b1;
        end
      end
      GAP: begin
        if (tmr == TW'(IDLE_GAP - 1)) begin
          tmr_n   = '0;
          state_n = IDLE;
        end else begin
          tmr_n = tmr + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      tmr       <= '0;
      div_cnt   <= '0;
      bit_cnt   <= 4'd0;
      shift_reg <= 16'h0000;
      ncs_q     <= 1'b1;
      sclk_q    <= 1'b0;
      copi_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_n;
      tmr       <= tmr_n;
      div_cnt   <= div_n;
      bit_cnt   <= bit_n;
      shift_reg <= shift_n;
      ncs_q     <= ncs_n;
      sclk_q    <= sclk_n;
      copi_q    <= copi_n;
      done_q    <= done_n;
    end
  end

endmodule

// File: tb/tb_spi_controller.sv
// tb/tb_spi_controller.sv - self-checking bench for spi_controller with a behavioural SPI register target
module tb_spi_controller;

  localparam int CLK_DIV   = 4;
  localparam int CS_LEAD   = 4;
  localparam int CS_LAG    = 4;
  localparam int IDLE_GAP  = 4;
  localparam int FRAME_LOW = CS_LEAD + 32 * CLK_DIV + CS_LAG;
  localparam int F_LOW     = 1 + 32 * 2 + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       req_valid, req_ready, req_rw;
  logic [6:0] req_addr;
  logic [7:0] req_data;
  logic       nCS, SCLK, COPI, busy, done;

  logic       f_req_valid, f_req_ready, f_req_rw;
  logic [6:0] f_req_addr;
  logic [7:0] f_req_data;
  logic       f_nCS, f_SCLK, f_COPI, f_busy, f_done;

  spi_controller dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_rw(req_rw), .req_addr(req_addr), .req_data(req_data),
    .nCS(nCS), .SCLK(SCLK), .COPI(COPI), .busy(busy), .done(done)
  );

  spi_controller #(.CLK_DIV(2), .CS_LEAD(1), .CS_LAG(1), .IDLE_GAP(1)) dut_fast (
    .clk(clk), .rst_n(rst_n), .req_valid(f_req_valid), .req_ready(f_req_ready),
    .req_rw(f_req_rw), .req_addr(f_req_addr), .req_data(f_req_data),
    .nCS(f_nCS), .SCLK(f_SCLK), .COPI(f_COPI), .busy(f_busy), .done(f_done)
  );

  int checks = 0;
  int passes = 0;

  // Target model: shift COPI in on SCLK rises, commit a write on nCS rise if exactly 16 bits with rw=1
  logic [15:0] bits = 16'h0, last_frame = 16'h0;
  int nbits = 0, low_cnt = 0, high_cnt = 0, frames = 0, done_cnt = 0, done_stray = 0;
  int last_nbits = 0, last_low = 0, last_high = 0;
  logic [7:0] regs [0:4];
  logic [7:0] exp_regs [0:4];

  logic [15:0] f_bits = 16'h0, f_last_frame = 16'h0;
  int f_nbits = 0, f_low = 0, f_frames = 0, f_last_low = 0, f_last_nbits = 0;
  logic [7:0] f_regs [0:4];

  initial begin
    for (int i = 0; i < 5; i++) begin
      regs[i] = 8'h00; exp_regs[i] = 8'h00; f_regs[i] = 8'h00;
    end
  end

  initial begin
    logic prev_sclk, prev_ncs;
    prev_sclk = 1'b0; prev_ncs = 1'b1;
    forever begin
      @(negedge clk);
      if (done) begin
        done_cnt++;
        if (!(nCS && !prev_ncs)) done_stray++;
      end
      if (!nCS) begin
        if (prev_ncs) begin
          last_high = high_cnt; bits = 16'h0; nbits = 0; low_cnt = 0;
        end
        low_cnt++;
        if (SCLK && !prev_sclk) begin
          bits = {bits[14:0], COPI}; nbits++;
        end
      end else begin
        if (!prev_ncs) begin
          last_frame = bits; last_nbits = nbits; last_low = low_cnt; frames++;
          if (nbits == 16 && bits[15] && bits[14:8] < 7'd5) regs[bits[10:8]] = bits[7:0];
          high_cnt = 0;
        end
        high_cnt++;
      end
      prev_sclk = SCLK; prev_ncs = nCS;
    end
  end

  initial begin
    logic prev_sclk, prev_ncs;
    prev_sclk = 1'b0; prev_ncs = 1'b1;
    forever begin
      @(negedge clk);
      if (!f_nCS) begin
        if (prev_ncs) begin
          f_bits = 16'h0; f_nbits = 0; f_low = 0;
        end
        f_low++;
        if (f_SCLK && !prev_sclk) begin
          f_bits = {f_bits[14:0], f_COPI}; f_nbits++;
        end
      end else if (!prev_ncs) begin
        f_last_frame = f_bits; f_last_nbits = f_nbits; f_last_low = f_low; f_frames++;
        if (f_nbits == 16 && f_bits[15] && f_bits[14:8] < 7'd5) f_regs[f_bits[10:8]] = f_bits[7:0];
      end
      prev_sclk = f_SCLK; prev_ncs = f_nCS;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic rw, input logic [6:0] a, input logic [7:0] d, output bit ok);
    int n, f0;
    logic rdy;
    f0 = frames; ok = 1'b0;
    req_rw = rw; req_addr = a; req_data = d; req_valid = 1'b1;
    n = 0;
    do begin rdy = req_ready; tick(); n++; end while (!rdy && n < 1000);
    req_valid = 1'b0;
    if (!rdy) return;
    n = 0;
    while (frames == f0 && n < 5000) begin tick(); n++; end
    ok = (frames != f0);
  endtask

  task automatic send_fast(input logic rw, input logic [6:0] a, input logic [7:0] d, output bit ok);
    int n, f0;
    logic rdy;
    f0 = f_frames; ok = 1'b0;
    f_req_rw = rw; f_req_addr = a; f_req_data = d; f_req_valid = 1'b1;
    n = 0;
    do begin rdy = f_req_ready; tick(); n++; end while (!rdy && n < 1000);
    f_req_valid = 1'b0;
    if (!rdy) return;
    n = 0;
    while (f_frames == f0 && n < 5000) begin tick(); n++; end
    ok = (f_frames != f0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b1; req_rw = 1'b1; req_addr = 7'h00; req_data = 8'h11;
    f_req_valid = 1'b0; f_req_rw = 1'b0; f_req_addr = 7'h00; f_req_data = 8'h00;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({nCS, SCLK, COPI, req_ready, busy, done} !== 6'b100000)
        $display("FAIL reset_outputs cycle %0d: {nCS,SCLK,COPI,ready,busy,done}=%b expected 100000", i,
                 {nCS, SCLK, COPI, req_ready, busy, done});
      else passes++;
    end
    req_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    checks++;
    if ({req_ready, busy, nCS} !== 3'b101)
      $display("FAIL reset_release: {ready,busy,nCS}=%b expected 101", {req_ready, busy, nCS});
    else passes++;
    checks++;
    if (frames !== 0) $display("FAIL reset_no_frame: frames=%0d expected 0", frames);
    else passes++;
  endtask

  task automatic test_single_write();
    bit ok;
    int d0;
    d0 = done_cnt;
    exp_regs[4] = 8'h80;
    send(1'b1, 7'h04, 8'h80, ok);
    checks++;
    if (!ok) $display("FAIL single_timeout: frame did not complete");
    else passes++;
    checks++;
    if (last_nbits !== 16) $display("FAIL single_rises: got %0d expected 16", last_nbits);
    else passes++;
    checks++;
    if (last_frame !== 16'h8480) $display("FAIL single_frame: got %h expected 8480", last_frame);
    else passes++;
    checks++;
    if (last_low !== FRAME_LOW) $display("FAIL single_ncs_low: got %0d expected %0d", last_low, FRAME_LOW);
    else passes++;
    checks++;
    if (done_cnt - d0 !== 1 || done_stray !== 0)
      $display("FAIL single_done: pulses %0d stray %0d expected 1 and 0", done_cnt - d0, done_stray);
    else passes++;
    checks++;
    if (regs[4] !== exp_regs[4]) $display("FAIL single_duty: got %h expected %h", regs[4], exp_regs[4]);
    else passes++;
  endtask

  task automatic test_back_to_back();
    int f0, d0, n;
    logic rdy;
    logic [15:0] fr1;
    bit got1;
    f0 = frames; d0 = done_cnt; got1 = 1'b0; fr1 = 16'h0;
    req_rw = 1'b1; req_addr = 7'h00; req_data = 8'hFF; req_valid = 1'b1;
    n = 0;
    do begin rdy = req_ready; tick(); n++; end while (!rdy && n < 1000);
    req_addr = 7'h01; req_data = 8'h0F;
    n = 0;
    do begin
      rdy = req_ready; tick(); n++;
      if (!got1 && frames == f0 + 1) begin fr1 = last_frame; got1 = 1'b1; end
    end while (!rdy && n < 1000);
    req_valid = 1'b0;
    n = 0;
    while (frames < f0 + 2 && n < 5000) begin tick(); n++; end
    exp_regs[0] = 8'hFF; exp_regs[1] = 8'h0F;
    checks++;
    if (fr1 !== 16'h80FF) $display("FAIL b2b_frame1: got %h expected 80FF", fr1);
    else passes++;
    checks++;
    if (last_frame !== 16'h810F) $display("FAIL b2b_frame2: got %h expected 810F", last_frame);
    else passes++;
    checks++;
    if (last_high !== IDLE_GAP + 1) $display("FAIL b2b_gap: nCS high %0d expected %0d", last_high, IDLE_GAP + 1);
    else passes++;
    checks++;
    if (done_cnt - d0 !== 2) $display("FAIL b2b_done: pulses %0d expected 2", done_cnt - d0);
    else passes++;
  endtask

  task automatic test_integration();
    bit ok;
    exp_regs[0] = 8'hA5;
    send(1'b1, 7'h00, 8'hA5, ok);
    checks++;
    if (!ok || regs[0] !== 8'hA5) $display("FAIL integ_out_7_0: got %h expected A5", regs[0]);
    else passes++;
    send(1'b1, 7'h04, 8'h80, ok);
    exp_regs[4] = 8'h80;
    checks++;
    if (!ok || regs[4] !== 8'h80) $display("FAIL integ_duty: got %h expected 80", regs[4]);
    else passes++;
    send(1'b0, 7'h00, 8'h3C, ok);
    checks++;
    if (!ok || last_frame !== 16'h003C || regs[0] !== 8'hA5)
      $display("FAIL integ_read_ignored: frame %h reg %h expected 003C and A5", last_frame, regs[0]);
    else passes++;
  endtask

  task automatic test_random_frames();
    bit ok;
    logic rw;
    logic [6:0] a;
    logic [7:0] d;
    for (int k = 0; k < 6; k++) begin
      rw = ($urandom_range(0, 3) != 0);
      a = 7'($urandom_range(0, 4));
      d = 8'($urandom);
      if (rw) exp_regs[a] = d;
      send(rw, a, d, ok);
      checks++;
      if (!ok || last_frame !== {rw, a, d} || last_nbits !== 16)
        $display("FAIL rand_frame %0d: got %h (%0d bits) expected %h", k, last_frame, last_nbits, {rw, a, d});
      else passes++;
      checks++;
      if ({regs[0], regs[1], regs[2], regs[3], regs[4]} !==
          {exp_regs[0], exp_regs[1], exp_regs[2], exp_regs[3], exp_regs[4]})
        $display("FAIL rand_regs %0d: got %h expected %h", k,
                 {regs[0], regs[1], regs[2], regs[3], regs[4]},
                 {exp_regs[0], exp_regs[1], exp_regs[2], exp_regs[3], exp_regs[4]});
      else passes++;
    end
  endtask

  task automatic test_mid_reset();
    bit ok;
    int d0, f0, n;
    logic rdy;
    d0 = done_cnt; f0 = frames;
    req_rw = 1'b1; req_addr = 7'h02; req_data = 8'h77; req_valid = 1'b1;
    n = 0;
    do begin rdy = req_ready; tick(); n++; end while (!rdy && n < 1000);
    req_valid = 1'b0;
    n = 0;
    do begin tick(); n++; end while (nbits != 8 && n < 2000);
    checks++;
    if (nbits !== 8) $display("FAIL midrst_reach: rises %0d expected 8", nbits);
    else passes++;
    rst_n = 1'b0;
    tick();
    checks++;
    if ({nCS, SCLK, COPI, busy} !== 4'b1000)
      $display("FAIL midrst_abort: {nCS,SCLK,COPI,busy}=%b expected 1000", {nCS, SCLK, COPI, busy});
    else passes++;
    tick();
    rst_n = 1'b1;
    tick(); tick();
    checks++;
    if (done_cnt !== d0 || frames !== f0 + 1 || last_nbits !== 8)
      $display("FAIL midrst_no_done: done %0d frames %0d bits %0d expected %0d %0d 8",
               done_cnt - d0, frames - f0, last_nbits, 0, 1);
    else passes++;
    checks++;
    if (regs[2] !== exp_regs[2]) $display("FAIL midrst_regs: got %h expected %h", regs[2], exp_regs[2]);
    else passes++;
    exp_regs[2] = 8'h55;
    send(1'b1, 7'h02, 8'h55, ok);
    checks++;
    if (!ok || regs[2] !== 8'h55) $display("FAIL midrst_recover: got %h expected 55", regs[2]);
    else passes++;
  endtask

  task automatic test_fast_divider();
    bit ok;
    logic [7:0] d;
    send_fast(1'b1, 7'h01, 8'hFF, ok);
    checks++;
    if (!ok || f_last_frame !== 16'h81FF || f_last_nbits !== 16)
      $display("FAIL fast_frame: got %h (%0d bits) expected 81FF", f_last_frame, f_last_nbits);
    else passes++;
    checks++;
    if (f_last_low !== F_LOW) $display("FAIL fast_ncs_low: got %0d expected %0d", f_last_low, F_LOW);
    else passes++;
    checks++;
    if (f_regs[1] !== 8'hFF) $display("FAIL fast_out_15_8: got %h expected FF", f_regs[1]);
    else passes++;
    d = 8'($urandom);
    send_fast(1'b1, 7'h03, d, ok);
    checks++;
    if (!ok || f_regs[3] !== d) $display("FAIL fast_rand: got %h expected %h", f_regs[3], d);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_back_to_back();
    test_integration();
    test_random_frames();
    test_mid_reset();
    test_fast_divider();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
